canrecv: RTL and testbench
==========================

// Module: canrecv
// PURPOSE
//  CAN 2.0A/B frame receiver; receive-side counterpart of the bit-stuffing transmitter. Bit-times
//  din, hard-syncs on SOF, destuffs, parses standard/extended data and remote frames, checks
//  CRC-15 (poly 15'h4599, init 0), drives the ACK slot, presents fields with a 1-cycle rxValid.
// PARAMETERS
//  IDLE_BITS  11  consecutive recessive samples required to leave WAIT_IDLE after an error
// PORTS
//  clk          in   1   single clock
//  rst          in   1   reset, asynchronous, active-high
//  quantaDiv    in   8   clocks per time quantum (0 treated as 1)
//  propQuanta   in   6   propagation segment, quanta
//  seg1Quanta   in   6   phase segment length, quanta (seg2 = seg1)
//  din          in   1   bus level, 0 = dominant
//  ackEn        in   1   enable dominant ACK on a good CRC
//  ackDrive     out  1   1 = drive dominant on bus
//  busy         out  1   frame in progress (SOF seen, not yet IDLE)
//  rxValid      out  1   1-cycle pulse: fields valid, frame error-free
//  rxId         out  29  extended: full ID; standard: ID in [28:18], [17:0]=0
//  rxFormat     out  1   1 = extended (IDE=1)
//  rxFrameType  out  3   0 = data, 1 = remote (RTR)
//  rxDatalen    out  4   DLC as received
//  rxData       out  64  left-justified, first byte [63:56], unreceived bytes 0
//  crcErr/stuffErr/formErr  out 1 each  1-cycle error pulses
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, timer/counters/CRC cleared; reset mid-frame aborts, no pulses.
//  - din passes a 2-flop synchronizer (2 clk latency); all references below use synced din.
//  - Bit timing: T = (1+prop+2*seg1)*qd clocks (16-bit counter); sample at count SP-1,
//    SP = (1+prop+seg1)*qd; counter wraps at T-1. No resync after hard sync at SOF.
//  - IDLE: falling edge on din -> counter=0, start. SOF sampled recessive -> IDLE, no error.
//  - States: IDLE, HDR, DATA, CRC, CRC_DLM, ACK, ACK_DLM, EOF, WAIT_IDLE.
//  - HDR: ID[28:18], bit12 (RTR std / SRR ext), IDE. IDE=0: r0, DLC[3:0]. IDE=1: ID[17:0],
//    RTR, r1, r0, DLC. Reserved bits not checked.
//  - DATA: 8*min(DLC,8) bits; skipped if RTR=1 or DLC=0. DLC>8 -> 8 bytes, rxDatalen=DLC.
//  - Destuff SOF..last CRC bit: after 5 equal sampled bits, next sample is a stuff bit, dropped;
//    if it equals the run -> stuffErr. Stuff bit counts toward the next run (run length 1).
//  - CRC shift: nxt=bit^crc[14]; crc={crc[13:0],0}; if nxt crc^=4599; SOF..data, destuffed.
//    15 received CRC bits compared at end of CRC; mismatch -> crcErr at CRC_DLM sample.
//  - CRC_DLM, ACK_DLM, 7 EOF bits must sample 1, else formErr. No stuffing after CRC.
//  - ackDrive=1 for exactly one bit period, counter 0 of ACK slot to end, iff ackEn and CRC ok.
//    ACK-slot sample ignored.
//  - rxValid: 1 clk after 7th EOF sample; rx* outputs update same cycle, hold until next
//    valid frame.
//  - Any error: pulse its flag 1 clk after offending sample; ackDrive=0 -> WAIT_IDLE. Needs
//    IDLE_BITS consecutive recessive samples (T-timed), then IDLE. Dominant sample resets count.
//  - busy=1 from SOF edge until IDLE re-entered; errors never raise rxValid.
// TESTING
//  1 qd=2,prop=1,seg1=2 (T=12,SP=8); std data ID 0x123,DLC2,A5 5A,ackEn=1 -> rxValid,
//    rxId[28:18]=0x123,rxData=64'hA55A_0000_0000_0000, ackDrive high 12 clk.
//  2 ext remote ID 29'h1ABCDEF0, DLC 3 -> rxFormat=1,rxFrameType=1,rxDatalen=3,rxData=0.
//  3 six dominant bits inside ID (stuff bit suppressed) -> stuffErr at 6th; no rxValid;
//    next good frame accepted after 11 recessive bits.
//  4 frame 1 with one CRC bit flipped -> crcErr, ackDrive never 1, no rxValid.
//  5 rst pulse mid-DATA, then frame 1 resent -> outputs 0 during rst; then normal rxValid.
//  6 3-clk dominant glitch in IDLE -> no busy after SP; no error pulses; returns IDLE.

Source files
------------

// File: rtl/canrecv.sv
// canrecv: CAN 2.0A/B frame receiver.
// Hard-syncs on SOF, samples one bit per bit time, destuffs, parses standard and
// extended data/remote frames, checks CRC-15, drives the ACK slot and presents
// the received fields with a one-cycle rxValid pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   quantaDiv           clocks per time quantum (0 behaves as 1)
//   propQuanta          propagation segment length, quanta
//   seg1Quanta          phase segment length, quanta (seg2 = seg1)
//   din                 bus level, 0 = dominant
//   ackEn               allow a dominant ACK on a good CRC
//   ackDrive            1 = drive dominant on the bus
//   busy                frame in progress
//   rxValid             one-cycle pulse, rx* fields valid
//   rxId/rxFormat/rxFrameType/rxDatalen/rxData   received fields
//   crcErr/stuffErr/formErr                      one-cycle error pulses
module canrecv #(
   parameter int unsigned IDLE_BITS = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  quantaDiv,
   input  logic [5:0]  propQuanta,
   input  logic [5:0]  seg1Quanta,
   input  logic        din,
   input  logic        ackEn,
   output logic        ackDrive,
   output logic        busy,
   output logic        rxValid,
   output logic [28:0] rxId,
   output logic        rxFormat,
   output logic [2:0]  rxFrameType,
   output logic [3:0]  rxDatalen,
   output logic [63:0] rxData,
   output logic        crcErr,
   output logic        stuffErr,
   output logic        formErr
);

   localparam int unsigned IDLE_CW  = $clog2(IDLE_BITS + 1);
   localparam logic [14:0] CRC_POLY = 15'h4599;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_DATA, S_CRC, S_CRC_DLM, S_ACK, S_ACK_DLM, S_EOF, S_WAIT_IDLE
   } state_t;

   state_t state, state_nxt;

   logic               din_s1, din_s2, din_q;
   logic [15:0]        bit_cnt;
   logic [2:0]         run_cnt;
   logic               run_val;
   logic [6:0]         fld_cnt;
   logic [36:0]        hdr_sr;
   logic               ide_w;
   logic [14:0]        crc;
   logic [13:0]        rx_crc;
   logic               crc_ok;
   logic [IDLE_CW-1:0] idle_cnt;
   logic [28:0]        id_w;
   logic               fmt_w, rtr_w;
   logic [3:0]         dlc_w;
   logic [63:0]        data_w;

   // Bit timing in clocks
   logic [7:0]  qd, tq_sp, tq_bit;
   logic [15:0] t_len, sp_len;
   assign qd     = (quantaDiv == 8'd0) ? 8'd1 : quantaDiv;
   assign tq_sp  = 8'd1 + 8'(propQuanta) + 8'(seg1Quanta);
   assign tq_bit = tq_sp + 8'(seg1Quanta);
   assign t_len  = 16'(tq_bit) * 16'(qd);
   assign sp_len = 16'(tq_sp) * 16'(qd);

   // Per-sample decode
   logic        din_fall, smp, wrap, in_stuff, stuff_slot, dbit, hdr_end, crc_fb;
   logic        stuff_err_c, crc_err_c, form_err_c, valid_c;
   logic [37:0] hdr_nxt;
   logic [6:0]  data_bits;
   logic [14:0] crc_nxt, rx_crc_nxt;
   logic        unused_bits;

   assign din_fall    = din_q & ~din_s2;
   assign smp         = (state != S_IDLE) && (bit_cnt == sp_len - 16'd1);
   assign wrap        = (bit_cnt == t_len - 16'd1);
   assign in_stuff    = state inside {S_HDR, S_DATA, S_CRC};
   // After five equal bits the next sample is a stuff bit and must differ
   assign stuff_slot  = in_stuff && (run_cnt == 3'd5);
   assign stuff_err_c = smp && stuff_slot && (din_s2 == run_val);
   assign dbit        = smp && in_stuff && !stuff_slot;
   // Header shift register skips SOF; DLC/RTR land at the same place for both formats
   assign hdr_nxt     = {hdr_sr, din_s2};
   assign hdr_end     = dbit && (state == S_HDR) &&
                        (((fld_cnt == 7'd18) && !ide_w) || ((fld_cnt == 7'd38) && ide_w));
   assign data_bits   = dlc_w[3] ? 7'd64 : {1'b0, dlc_w[2:0], 3'b000};
   assign crc_fb      = din_s2 ^ crc[14];
   assign crc_nxt     = {crc[13:0], 1'b0} ^ (crc_fb ? CRC_POLY : 15'd0);
   assign rx_crc_nxt  = {rx_crc, din_s2};
   assign unused_bits = ^{hdr_nxt[26:25], hdr_nxt[5:4]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-sample pulses
   always_comb begin
      state_nxt  = state;
      crc_err_c  = 1'b0;
      form_err_c = 1'b0;
      valid_c    = 1'b0;
      case (state)
         S_IDLE:    if (din_fall) state_nxt = S_HDR;
         S_HDR: begin
            if (stuff_err_c)                            state_nxt = S_WAIT_IDLE;
            else if (dbit && (fld_cnt == 7'd0) && din_s2) state_nxt = S_IDLE;
            else if (hdr_end)
               state_nxt = (hdr_nxt[6] || (hdr_nxt[3:0] == 4'd0)) ? S_CRC : S_DATA;
         end
         S_DATA: begin
            if (stuff_err_c)                                   state_nxt = S_WAIT_IDLE;
            else if (dbit && (fld_cnt == data_bits - 7'd1))    state_nxt = S_CRC;
         end
         S_CRC: begin
            if (stuff_err_c)                       state_nxt = S_WAIT_IDLE;
            else if (dbit && (fld_cnt == 7'd14))   state_nxt = S_CRC_DLM;
         end
         S_CRC_DLM: if (smp) begin
            if (!crc_ok) begin
               crc_err_c = 1'b1;
               state_nxt = S_WAIT_IDLE;
            end else if (!din_s2) begin
               form_err_c = 1'b1;
               state_nxt  = S_WAIT_IDLE;
            end else begin
               state_nxt = S_ACK;
            end
         end
         S_ACK:     if (smp) state_nxt = S_ACK_DLM;
         S_ACK_DLM: if (smp) begin
            if (!din_s2) begin
               form_err_c = 1'b1;
               state_nxt  = S_WAIT_IDLE;
            end else begin
               state_nxt = S_EOF;
            end
         end
         S_EOF: if (smp) begin
            if (!din_s2) begin
               form_err_c = 1'b1;
               state_nxt  = S_WAIT_IDLE;
            end else if (fld_cnt == 7'd6) begin
               valid_c   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WAIT_IDLE:
            if (smp && din_s2 && (idle_cnt == IDLE_CW'(IDLE_BITS - 1))) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Synchronizer, bit timer, destuffing, field capture and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {din_s1, din_s2, din_q} <= 3'b111;
         bit_cnt     <= '0;
         run_cnt     <= '0;
         run_val     <= 1'b1;
         fld_cnt     <= '0;
         hdr_sr      <= '0;
         ide_w       <= 1'b0;
         crc         <= '0;
         rx_crc      <= '0;
         crc_ok      <= 1'b0;
         idle_cnt    <= '0;
         id_w        <= '0;
         fmt_w       <= 1'b0;
         rtr_w       <= 1'b0;
         dlc_w       <= '0;
         data_w      <= '0;
         ackDrive    <= 1'b0;
         busy        <= 1'b0;
         rxValid     <= 1'b0;
         rxId        <= '0;
         rxFormat    <= 1'b0;
         rxFrameType <= '0;
         rxDatalen   <= '0;
         rxData      <= '0;
         crcErr      <= 1'b0;
         stuffErr    <= 1'b0;
         formErr     <= 1'b0;
      end else begin
         din_s1 <= din;
         din_s2 <= din_s1;
         din_q  <= din_s2;

         // Hard sync: the bit time restarts on the SOF edge and free-runs afterwards
         if (state == S_IDLE) bit_cnt <= '0;
         else                 bit_cnt <= wrap ? 16'd0 : bit_cnt + 16'd1;

         if ((state == S_IDLE) && din_fall) begin
            run_cnt <= '0;
            run_val <= 1'b1;
            hdr_sr  <= '0;
            ide_w   <= 1'b0;
            crc     <= '0;
            rx_crc  <= '0;
            crc_ok  <= 1'b0;
            data_w  <= '0;
         end

         // A stuff bit starts a new run of length one
         if (smp && in_stuff) begin
            if (stuff_slot || (din_s2 != run_val)) begin
               run_val <= din_s2;
               run_cnt <= 3'd1;
            end else begin
               run_cnt <= run_cnt + 3'd1;
            end
         end

         if (state_nxt != state)                      fld_cnt <= '0;
         else if (dbit || ((state == S_EOF) && smp))  fld_cnt <= fld_cnt + 7'd1;

         if (dbit && ((state == S_HDR) || (state == S_DATA))) crc <= crc_nxt;

         if (dbit && (state == S_HDR)) begin
            if (fld_cnt == 7'd13) ide_w  <= din_s2;
            if (fld_cnt != 7'd0)  hdr_sr <= hdr_nxt[36:0];
            if (hdr_end) begin
               id_w  <= ide_w ? {hdr_nxt[37:27], hdr_nxt[24:7]} : {hdr_nxt[17:7], 18'd0};
               fmt_w <= ide_w;
               rtr_w <= hdr_nxt[6];
               dlc_w <= hdr_nxt[3:0];
            end
         end

         if (dbit && (state == S_DATA)) data_w[6'(7'd63 - fld_cnt)] <= din_s2;

         if (dbit && (state == S_CRC)) begin
            rx_crc <= rx_crc_nxt[13:0];
            if (fld_cnt == 7'd14) crc_ok <= (rx_crc_nxt == crc);
         end

         // Consecutive recessive samples while waiting for bus idle
         if (state != S_WAIT_IDLE) idle_cnt <= '0;
         else if (smp)             idle_cnt <= din_s2 ? idle_cnt + IDLE_CW'(1) : '0;

         // ACK drive covers exactly the ACK bit: from its counter 0 to its last clock
         if ((state == S_ACK) && wrap && ackEn && crc_ok)             ackDrive <= 1'b1;
         else if (((state == S_ACK_DLM) && wrap) || (state_nxt == S_WAIT_IDLE)) ackDrive <= 1'b0;

         busy     <= (state_nxt != S_IDLE);
         rxValid  <= valid_c;
         crcErr   <= crc_err_c;
         stuffErr <= stuff_err_c;
         formErr  <= form_err_c;
         if (valid_c) begin
            rxId        <= id_w;
            rxFormat    <= fmt_w;
            rxFrameType <= {2'b00, rtr_w};
            rxDatalen   <= dlc_w;
            rxData      <= data_w;
         end
      end
   end

endmodule

// File: tb/tb_canrecv.sv
// tb_canrecv: directed bench for canrecv.
// Builds stuffed CAN frames (CRC computed locally), drives them bit-timed onto din,
// counts output pulses on the falling clock edge and compares fields with
// hand-derived values.
module tb_canrecv;

   localparam int T_CLK = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  quantaDiv;
   logic [5:0]  propQuanta;
   logic [5:0]  seg1Quanta;
   logic        din;
   logic        ackEn;
   logic        ackDrive, busy, rxValid, rxFormat, crcErr, stuffErr, formErr;
   logic [28:0] rxId;
   logic [2:0]  rxFrameType;
   logic [3:0]  rxDatalen;
   logic [63:0] rxData;

   canrecv #(.IDLE_BITS(11)) dut (
      .clk(clk), .rst(rst), .quantaDiv(quantaDiv), .propQuanta(propQuanta),
      .seg1Quanta(seg1Quanta), .din(din), .ackEn(ackEn), .ackDrive(ackDrive),
      .busy(busy), .rxValid(rxValid), .rxId(rxId), .rxFormat(rxFormat),
      .rxFrameType(rxFrameType), .rxDatalen(rxDatalen), .rxData(rxData),
      .crcErr(crcErr), .stuffErr(stuffErr), .formErr(formErr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_valid = 0, n_crc = 0, n_stuff = 0, n_form = 0, n_ack = 0, n_busy = 0;
   int v0, c0, s0, f0, a0, b0;

   logic raw_q[$];
   logic tx_q[$];

   // Output activity counters
   always @(negedge clk) begin
      if (!rst) begin
         if (rxValid)  n_valid++;
         if (crcErr)   n_crc++;
         if (stuffErr) n_stuff++;
         if (formErr)  n_form++;
         if (ackDrive) n_ack++;
         if (busy)     n_busy++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic [14:0] r;
      r = {c[13:0], 1'b0};
      if (b ^ c[14]) r = r ^ 15'h4599;
      return r;
   endfunction

   // Frame bits SOF..EOF; flip >= 0 inverts that CRC bit (14 = first sent)
   task automatic build_frame(input logic ext, input logic [28:0] id, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data, input int flip);
      logic [14:0] crc;
      int          nbits, run;
      logic        last;
      raw_q.delete();
      tx_q.delete();
      raw_q.push_back(1'b0);
      for (int i = 28; i >= 18; i--) raw_q.push_back(id[i]);
      if (!ext) begin
         raw_q.push_back(rtr); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
      end else begin
         raw_q.push_back(1'b1); raw_q.push_back(1'b1);
         for (int i = 17; i >= 0; i--) raw_q.push_back(id[i]);
         raw_q.push_back(rtr); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
      nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
      for (int i = 0; i < nbits; i++) raw_q.push_back(data[63 - i]);
      crc = '0;
      foreach (raw_q[i]) crc = crc_step(crc, raw_q[i]);
      for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i] ^ (i == flip));
      run  = 0;
      last = 1'b1;
      foreach (raw_q[i]) begin
         tx_q.push_back(raw_q[i]);
         if (raw_q[i] == last) run++;
         else begin
            run  = 1;
            last = raw_q[i];
         end
         if ((run == 5) && (i < raw_q.size() - 1)) begin
            tx_q.push_back(~last);
            last = ~last;
            run  = 1;
         end
      end
      // CRC delimiter, ACK slot (recessive from sender), ACK delimiter, 7 EOF
      for (int i = 0; i < 10; i++) tx_q.push_back(1'b1);
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         din = tx_q[i];
         repeat (T_CLK) @(negedge clk);
      end
   endtask

   task automatic idle_bits(input int n);
      din = 1'b1;
      repeat (n * T_CLK) @(negedge clk);
   endtask

   task automatic snap();
      v0 = n_valid; c0 = n_crc; s0 = n_stuff; f0 = n_form; a0 = n_ack; b0 = n_busy;
   endtask

   task automatic frame1(input int flip);
      build_frame(1'b0, {11'h123, 18'd0}, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, flip);
   endtask

   initial begin
      rst = 1'b1; din = 1'b1; ackEn = 1'b1;
      quantaDiv = 8'd2; propQuanta = 6'd1; seg1Quanta = 6'd2;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(rxValid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ack", 64'(ackDrive), 64'd0);
      chk("rst_errs", 64'({crcErr, stuffErr, formErr}), 64'd0);
      chk("rst_data", rxData, 64'd0);
      rst = 1'b0;
      idle_bits(2);

      // Standard data frame
      snap();
      frame1(-1);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t1_valid", 64'(n_valid - v0), 64'd1);
      chk("t1_id", 64'(rxId), 64'({11'h123, 18'd0}));
      chk("t1_fmt", 64'({rxFormat, rxFrameType}), 64'd0);
      chk("t1_dlc", 64'(rxDatalen), 64'd2);
      chk("t1_data", rxData, 64'hA55A_0000_0000_0000);
      chk("t1_ack_clks", 64'(n_ack - a0), 64'd12);
      chk("t1_errs", 64'((n_crc - c0) + (n_stuff - s0) + (n_form - f0)), 64'd0);
      chk("t1_busy_end", 64'(busy), 64'd0);

      // Extended remote frame
      snap();
      build_frame(1'b1, 29'h1ABCDEF0, 1'b1, 4'd3, 64'd0, -1);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t2_valid", 64'(n_valid - v0), 64'd1);
      chk("t2_id", 64'(rxId), 64'h1ABCDEF0);
      chk("t2_fmt", 64'(rxFormat), 64'd1);
      chk("t2_type", 64'(rxFrameType), 64'd1);
      chk("t2_dlc", 64'(rxDatalen), 64'd3);
      chk("t2_data", rxData, 64'd0);

      // DLC above 8: eight bytes, DLC reported as received
      snap();
      build_frame(1'b0, {11'h555, 18'd0}, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, -1);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t7_valid", 64'(n_valid - v0), 64'd1);
      chk("t7_id", 64'(rxId), 64'({11'h555, 18'd0}));
      chk("t7_dlc", 64'(rxDatalen), 64'd9);
      chk("t7_data", rxData, 64'h0123_4567_89AB_CDEF);

      // Six dominant bits inside the ID with the stuff bit missing
      snap();
      tx_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      send_bits(8);
      idle_bits(14);
      chk("t3_stuff", 64'(n_stuff - s0), 64'd1);
      chk("t3_valid", 64'(n_valid - v0), 64'd0);
      chk("t3_other_errs", 64'((n_crc - c0) + (n_form - f0)), 64'd0);
      snap();
      frame1(-1);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t3_recover_valid", 64'(n_valid - v0), 64'd1);
      chk("t3_recover_data", rxData, 64'hA55A_0000_0000_0000);

      // Corrupted CRC bit
      snap();
      frame1(3);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t4_crc", 64'(n_crc - c0), 64'd1);
      chk("t4_ack", 64'(n_ack - a0), 64'd0);
      chk("t4_valid", 64'(n_valid - v0), 64'd0);
      chk("t4_other_errs", 64'((n_stuff - s0) + (n_form - f0)), 64'd0);
      chk("t4_hold_data", rxData, 64'hA55A_0000_0000_0000);

      // Reset during the data field, then a full frame
      snap();
      frame1(-1);
      send_bits(24);
      rst = 1'b1;
      din = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_rst_outs", 64'({rxValid, busy, ackDrive, crcErr, stuffErr, formErr}), 64'd0);
      chk("t5_rst_id", 64'({rxId, rxFormat, rxFrameType, rxDatalen}), 64'd0);
      chk("t5_rst_data", rxData, 64'd0);
      rst = 1'b0;
      idle_bits(2);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t5_valid", 64'(n_valid - v0), 64'd1);
      chk("t5_data", rxData, 64'hA55A_0000_0000_0000);
      chk("t5_errs", 64'((n_crc - c0) + (n_stuff - s0) + (n_form - f0)), 64'd0);

      // Short dominant glitch while idle
      snap();
      din = 1'b0;
      repeat (3) @(negedge clk);
      din = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_busy_after", 64'(busy), 64'd0);
      chk("t6_busy_short", 64'(((n_busy - b0) > 0) && ((n_busy - b0) <= T_CLK)), 64'd1);
      chk("t6_errs", 64'((n_crc - c0) + (n_stuff - s0) + (n_form - f0)), 64'd0);
      chk("t6_valid", 64'(n_valid - v0), 64'd0);
      idle_bits(2);
      snap();
      frame1(-1);
      send_bits(tx_q.size());
      idle_bits(14);
      chk("t6_next_valid", 64'(n_valid - v0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
